// File: rtl/led_driver.sv
// N-channel LED driver with per-channel off / on / blink / breathe modes.
// A shared prescaler drives blink. A shared PWM counter and triangle ramp drive breathe.
// Output polarity is selectable with ACTIVE_LOW.
//
// Ramp direction FSM:
//   state    | meaning
//   DIR_UP   | level climbs one step per ramp step; holds one step at the top, then turns
//   DIR_DOWN | level falls one step per ramp step; holds one step at zero, then turns
//
// led and tick are registered from the next-state values of the shared timers.
// This makes a blink toggle on led land in the same cycle as its tick pulse.
// It also keeps each PWM period aligned to pwm_cnt == 0.
module led_driver #(
    parameter int NUM_LEDS    = 4,
    parameter int CLK_HZ      = 25000000,
    parameter int BLINK_HZ    = 1,
    parameter int PWM_BITS    = 8,
    parameter int BREATHE_DIV = 48,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [2*NUM_LEDS-1:0] mode,
    output logic [NUM_LEDS-1:0]   led,
    output logic                  tick
);

    localparam int DIV   = CLK_HZ / (2 * BLINK_HZ);
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BR_W  = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;

    localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(DIV - 1);
    localparam logic [BR_W-1:0]     BR_MAX  = BR_W'(BREATHE_DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
    localparam logic [PWM_BITS-1:0] LVL_MIN = '0;
    localparam logic                AL      = (ACTIVE_LOW != 0);

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_ON      = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PRE_W-1:0]    pre_cnt;
    logic                blink_phase;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BR_W-1:0]     br_cnt;
    logic [PWM_BITS-1:0] level;
    dir_t                dir;

    logic                pre_wrap;
    logic [PRE_W-1:0]    pre_nxt;
    logic                phase_nxt;
    logic                pwm_wrap;
    logic [PWM_BITS-1:0] pwm_nxt;
    logic [BR_W-1:0]     br_nxt;
    logic                ramp_step;
    logic [PWM_BITS-1:0] level_nxt;
    dir_t                dir_nxt;
    logic                pwm_on_nxt;
    logic [NUM_LEDS-1:0] lit_nxt;

    // Next-state of the shared timers, ramp FSM and per-channel lit decode
    always_comb begin
        pre_wrap  = (pre_cnt == PRE_MAX);
        pre_nxt   = pre_wrap ? '0 : pre_cnt + PRE_W'(1);
        phase_nxt = blink_phase ^ pre_wrap;

        pwm_wrap  = (pwm_cnt == LVL_MAX);
        pwm_nxt   = pwm_cnt + PWM_BITS'(1);

        br_nxt    = br_cnt;
        if (pwm_wrap) begin
            br_nxt = (br_cnt == BR_MAX) ? '0 : br_cnt + BR_W'(1);
        end
        ramp_step = pwm_wrap && (br_cnt == BR_MAX);

        level_nxt = level;
        dir_nxt   = dir;
        if (ramp_step) begin
            case (dir)
                DIR_UP: begin
                    if (level == LVL_MAX) dir_nxt = DIR_DOWN;
                    else                  level_nxt = level + PWM_BITS'(1);
                end
                DIR_DOWN: begin
                    if (level == LVL_MIN) dir_nxt = DIR_UP;
                    else                  level_nxt = level - PWM_BITS'(1);
                end
                default: dir_nxt = DIR_UP;
            endcase
        end

        pwm_on_nxt = (pwm_nxt < level_nxt);

        lit_nxt = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode[2*i +: 2])
                MODE_OFF:     lit_nxt[i] = 1'b0;
                MODE_ON:      lit_nxt[i] = 1'b1;
                MODE_BLINK:   lit_nxt[i] = phase_nxt;
                MODE_BREATHE: lit_nxt[i] = pwm_on_nxt;
                default:      lit_nxt[i] = 1'b0;
            endcase
        end
    end

    // State registers and registered outputs; async reset forces all LEDs unlit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_cnt     <= '0;
            blink_phase <= 1'b0;
            pwm_cnt     <= '0;
            br_cnt      <= '0;
            level       <= '0;
            dir         <= DIR_UP;
            tick        <= 1'b0;
            led         <= {NUM_LEDS{AL}};
        end else begin
            pre_cnt     <= pre_nxt;
            blink_phase <= phase_nxt;
            pwm_cnt     <= pwm_nxt;
            br_cnt      <= br_nxt;
            level       <= level_nxt;
            dir         <= dir_nxt;
            tick        <= pre_wrap;
            led         <= lit_nxt ^ {NUM_LEDS{AL}};
        end
    end

endmodule

// File: tb/tb_led_driver.sv
// Bench for led_driver: static vector table, hand sequences and random modes vs an arithmetic model.
module tb_led_driver;

    localparam int NL     = 4;
    localparam int CLKHZ  = 16;
    localparam int BHZ    = 2;
    localparam int PB     = 2;
    localparam int BD     = 1;
    localparam int DIV    = CLKHZ / (2 * BHZ);
    localparam int PER    = 1 << PB;
    localparam int LMAX   = PER - 1;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    mode   = 8'h00;
    logic [NL-1:0] led;
    logic          tick;

    int total = 0;
    int bad   = 0;
    int n     = 0;   // rising edges since reset release

    led_driver #(
        .NUM_LEDS(NL), .CLK_HZ(CLKHZ), .BLINK_HZ(BHZ),
        .PWM_BITS(PB), .BREATHE_DIV(BD), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .resetn(resetn), .mode(mode), .led(led), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] m;
        logic [3:0] exp;
    } vec_t;

    // Brightness after s ramp steps: triangle 0..LMAX, each endpoint held one step
    function automatic int ref_level(input int edges);
        int s, p;
        s = (edges / PER) / BD;
        p = s % (2 * PER);
        return (p <= LMAX) ? p : (2 * LMAX + 1 - p);
    endfunction

    function automatic logic [3:0] ref_led(input int edges, input logic [7:0] m);
        logic [3:0] r;
        logic [1:0] cm;
        int phase, pwm, lvl;
        logic lit;
        if (edges == 0) return 4'b1111;
        phase = (edges / DIV) % 2;
        pwm   = edges % PER;
        lvl   = ref_level(edges);
        r     = 4'b1111;
        for (int i = 0; i < NL; i++) begin
            cm = m[2*i +: 2];
            case (cm)
                2'b00:   lit = 1'b0;
                2'b01:   lit = 1'b1;
                2'b10:   lit = (phase == 1);
                default: lit = (pwm < lvl);
            endcase
            r[i] = ~lit;
        end
        return r;
    endfunction

    function automatic logic ref_tick(input int edges);
        return (edges > 0) && (edges % DIV == 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        if (resetn) n++;
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_led"}, 32'(led), 32'(ref_led(n, mode)));
        check({tag, "_tick"}, 32'(tick), 32'(ref_tick(n)));
    endtask

    // Assert reset between clock edges, hold for 'hold' edges, release between edges
    task automatic pulse_reset(input int hold);
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("rst_async_led", 32'(led), 32'hF);
        check("rst_async_tick", 32'(tick), 32'h0);
        repeat (hold) @(posedge clk);
        #3 resetn = 1'b1;
        n = 0;
    endtask

    vec_t tbl[6];
    int   exp_cnt[10];
    int   cnt;

    initial begin
        tbl[0] = '{8'b00_00_00_00, 4'b1111};
        tbl[1] = '{8'b01_01_01_01, 4'b0000};
        tbl[2] = '{8'b00_01_00_01, 4'b1010};
        tbl[3] = '{8'b01_00_01_00, 4'b0101};
        tbl[4] = '{8'b00_00_00_01, 4'b1110};
        tbl[5] = '{8'b01_00_00_00, 4'b0111};
        exp_cnt = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};

        // T1: reset held, clock running, modes changing
        for (int i = 0; i < 5; i++) begin
            mode = 8'($urandom);
            @(negedge clk);
            check("t1_led", 32'(led), 32'hF);
            check("t1_tick", 32'(tick), 32'h0);
        end
        @(posedge clk);
        #3 resetn = 1'b1;
        n = 0;

        // Static table
        for (int i = 0; i < 6; i++) begin
            mode = tbl[i].m;
            for (int k = 0; k < 3; k++) begin
                clk_step();
                check("tbl_led", 32'(led), 32'(tbl[i].exp));
            end
        end

        // T2: static pattern held 64 clocks
        mode = 8'b00_01_00_01;
        for (int k = 0; k < 64; k++) begin
            clk_step();
            check("t2_led", 32'(led), 32'hA);
        end

        // T3: all blink from reset
        pulse_reset(2);
        mode = 8'b10_10_10_10;
        for (int k = 1; k <= 24; k++) begin
            clk_step();
            check("t3_led", 32'(led), ((k / 4) % 2 == 1) ? 32'h0 : 32'hF);
            check("t3_tick", 32'(tick), (k % 4 == 0) ? 32'h1 : 32'h0);
        end

        // T4: breathe ch0, lit cycles per PWM period follow the triangle walk
        pulse_reset(2);
        mode = 8'b00_00_00_11;
        for (int p = 0; p < 10; p++) begin
            cnt = 0;
            for (int k = (p == 0) ? 1 : 0; k < PER; k++) begin
                clk_step();
                if (led[0] == 1'b0) cnt++;
                check_model("t4");
            end
            check("t4_litcount", 32'(cnt), 32'(exp_cnt[p]));
        end

        // T5: ch0 blink -> on mid-phase, then back to blink
        pulse_reset(2);
        mode = 8'b10_10_10_10;
        clk_step();
        clk_step();
        check("t5_pre", 32'(led), 32'hF);
        mode = 8'b10_10_10_01;
        clk_step();
        check("t5_on", 32'(led[0]), 32'h0);
        check("t5_ch1", 32'(led[1]), 32'h1);
        mode = 8'b10_10_10_10;
        for (int k = 0; k < 10; k++) begin
            clk_step();
            check("t5_rejoin", 32'(led[0]), 32'(led[1]));
            check_model("t5");
        end

        // T6: async reset pulse mid-breathe, ramp restarts from level 0 going up
        pulse_reset(2);
        mode = 8'b11_00_00_11;
        for (int k = 0; k < 10; k++) clk_step();
        pulse_reset(1);
        for (int p = 0; p < 5; p++) begin
            cnt = 0;
            for (int k = (p == 0) ? 1 : 0; k < PER; k++) begin
                clk_step();
                if (led[0] == 1'b0) cnt++;
                check_model("t6");
            end
            check("t6_litcount", 32'(cnt), 32'(exp_cnt[p]));
        end

        // Random mode changes with occasional reset pulses
        pulse_reset(1);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) == 0) mode = 8'($urandom);
            if ($urandom_range(99) == 0) pulse_reset($urandom_range(2, 1));
            clk_step();
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
